reverb_param_avm_writer: RTL
============================

# reverb_param_avm_writer

Avalon-MM master that drives the reverb's parameter PIO slaves (pre-delay, decay, mix, ...) from fabric-side sources such as front-panel encoders. Requests are queued in a small FIFO and issued as single Avalon-MM write transfers, honouring `waitrequest`. The block is the initiator counterpart of the output-PIO register slaves and sits between the local control logic and the Qsys interconnect.

## Interface
Parameters:
- `ADDR_W`, 2: Avalon word-address width.
- `DATA_W`, 10: payload width; zero-extended to 32 bits on `avm_writedata`.
- `FIFO_DEPTH`, 4: request FIFO depth; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO not full.
- `req_addr`  in  ADDR_W  target address.
- `req_data`  in  DATA_W  value to write.
- `avm_address`  out  ADDR_W  Avalon address.
- `avm_chipselect`  out  1  transfer active.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_read_n`  out  1  active-low read strobe (readback only).
- `avm_writedata`  out  32  `{(32-DATA_W)'b0, data}`.
- `avm_readdata`  in  32  slave read data.
- `avm_waitrequest`  in  1  slave stall.
- `busy`  out  1  FIFO non-empty or transfer in flight.
- `wr_count`  out  16  completed writes, wraps 0xFFFF→0.
- `err_flag`  out  1  sticky readback mismatch.
- `err_clr`  in  1  clears `err_flag`.

## Operation
- FIFO push on `req_valid && req_ready`; order preserved; no drops; `req_ready = !full`.
- States: IDLE, WRITE, READ (readback build only).
- IDLE: if FIFO non-empty, pop the head into the hold register {addr, data}; next state WRITE. No pop in any other state.
- WRITE: `avm_chipselect=1`, `avm_write_n=0`, address/writedata from the hold register, all held stable while `avm_waitrequest=1`. The transfer completes on the first cycle with `avm_waitrequest=0`: `wr_count` increments, then go to READ (readback) or IDLE.
- READ: `avm_chipselect=1`, `avm_read_n=0`, same address. Completes on the first cycle with `avm_waitrequest=0` (read latency 0): compare `avm_readdata[DATA_W-1:0]` with the hold data; on mismatch set `err_flag`. Next state IDLE.
- Outside WRITE/READ: `avm_chipselect=0`, `avm_write_n=1`, `avm_read_n=1`; address/writedata undefined-but-stable (hold register).
- `err_flag`: set has priority over `err_clr` in the same cycle.
- `busy = (state != IDLE) || !empty`.
- Simultaneous push and pop on a full FIFO: the push is refused (`req_ready` is 0 that cycle); a full-then-pop frees the slot for the next cycle.

## Timing
- Reset values: state IDLE, FIFO empty, `req_ready=1`, `avm_chipselect=0`, `avm_write_n=1`, `avm_read_n=1`, `avm_address=0`, `avm_writedata=0`, `wr_count=0`, `err_flag=0`, `busy=0`.
- All outputs are registered or decoded from registered state; there is no combinational path from `req_valid` to `avm_*`.
- Latency: a push into an empty FIFO in cycle N pops in N+1 and asserts the write strobe in N+2. With zero wait, `wr_count` updates in N+3.
- Throughput with zero wait: one write per 2 cycles (IDLE + WRITE), or one per 3 cycles with readback.
- Reset mid-transfer aborts immediately: strobes are deasserted asynchronously and the FIFO contents are discarded.

## Configuration
- `REVERB_PARAM_READBACK_EN` defined: the READ state, compare logic and `err_flag` are built; `avm_read_n` toggles as described.
- `REVERB_PARAM_READBACK_EN` undefined: the READ state is removed, WRITE→IDLE directly, `avm_read_n` is tied to 1, `err_flag` is tied to 0, and `err_clr` is ignored.

## Test plan
- Reset, then single request addr 0, data 0x3FF with zero wait -> one write cycle with `avm_address=0` and `avm_writedata=0x000003FF`; `wr_count=1`; `busy` falls afterwards.
- Same request with `waitrequest` high for 3 cycles -> strobes and data held 4 cycles; exactly one completion; `wr_count=1`.
- Push 5 requests back-to-back with `waitrequest` stuck high -> `req_ready` is 0 after 5 accepted pushes (4 in the FIFO + 1 in the hold register); after release, the writes appear in push order and `wr_count=5`.
- Readback build: slave returns 0x005 for a write of 0x006 -> `err_flag=1`; assert `err_clr` -> `err_flag=0`. A correct readback leaves the flag clear.
- Assert `reset_n` low during WRITE with wait -> strobes drop in the same cycle; after release, `wr_count=0`, `req_ready=1`, and no further writes occur.
- Preload `wr_count` near wrap via 65536 writes (or force) -> `wr_count` rolls 0xFFFF→0x0000.

Source files
------------

// File: rtl/reverb_param_avm_writer.sv
// reverb_param_avm_writer
//   Avalon-MM master that issues single write transfers to the reverb
//   parameter PIO slaves. Requests from fabric-side sources are queued in a
//   small FIFO and written one at a time, honouring avm_waitrequest.
//
//   Optional feature macro: REVERB_PARAM_READBACK_EN
//     defined   : each write is followed by a zero-latency readback of the
//                 same address; a mismatch sets the sticky err_flag.
//     undefined : WRITE returns straight to IDLE, avm_read_n=1, err_flag=0.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   req_valid/ready     request handshake (ready = FIFO not full)
//   req_addr, req_data  request target word address and payload
//   avm_*               Avalon-MM master signals
//   busy                FIFO non-empty or transfer in flight
//   wr_count            completed writes (wraps)
//   err_flag, err_clr   sticky readback mismatch flag and its clear
module reverb_param_avm_writer #(
    parameter int ADDR_W     = 2,
    parameter int DATA_W     = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic              avm_read_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic [15:0]       wr_count,
    output logic              err_flag,
    input  logic              err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

`ifdef REVERB_PARAM_READBACK_EN
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
`else
    typedef enum logic [0:0] {IDLE, WRITE} state_t;
`endif

    state_t state, state_next;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr, rd_ptr;
    logic              full, empty, push, pop;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    logic [15:0]       count_q;
    logic              wr_done;
    logic              unused_inputs;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign req_ready = !full;
    assign push      = req_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign wr_done   = (state == WRITE) && !avm_waitrequest;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {req_addr, req_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            count_q   <= '0;
            state     <= IDLE;
        end else begin
            state <= state_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                 <= rd_ptr + 1'b1;
                {hold_addr, hold_data} <= fifo_mem[rd_ptr[PTR_W-1:0]];
            end
            if (wr_done)
                count_q <= count_q + 16'd1;
        end
    end

    always_comb begin
        state_next     = state;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        case (state)
            IDLE: begin
                if (!empty)
                    state_next = WRITE;
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                if (!avm_waitrequest) begin
`ifdef REVERB_PARAM_READBACK_EN
                    state_next = READ;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef REVERB_PARAM_READBACK_EN
            READ: begin
                avm_chipselect = 1'b1;
                if (!avm_waitrequest)
                    state_next = IDLE;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

`ifdef REVERB_PARAM_READBACK_EN
    logic rd_mismatch;

    assign avm_read_n  = (state != READ);
    assign rd_mismatch = (state == READ) && !avm_waitrequest &&
                         (avm_readdata[DATA_W-1:0] != hold_data);

    // A mismatch in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_flag <= 1'b0;
        else if (rd_mismatch)
            err_flag <= 1'b1;
        else if (err_clr)
            err_flag <= 1'b0;
    end

    assign unused_inputs = ^avm_readdata;
`else
    assign avm_read_n    = 1'b1;
    assign err_flag      = 1'b0;
    assign unused_inputs = ^{avm_readdata, err_clr};
`endif

    assign avm_address   = hold_addr;
    assign avm_writedata = {{(32-DATA_W){1'b0}}, hold_data};
    assign wr_count      = count_q;
    assign busy          = (state != IDLE) || !empty;

endmodule
